fm_route_mac_seq: RTL and testbench
===================================

# fm_route_mac_seq

Time-multiplexed, parametrised modulation-matrix router for the FM voice engine. For each of `N_TGT` routing targets, it sums `N_SRC` products of routing weight × voice value read from the voice-value RAM. One multiplier is shared across all products, and results are saturated to signed Q1.(DW-1). It replaces the fixed 4-target, 2-source parallel multiply-add block, trading DSP count for `N_TGT*N_SRC` cycles per frame.

## Interface
- `DW`, 32: data width; weights, values and targets are signed Q1.(DW-1).
- `VOICE_AW`, 4: voice-value RAM address width.
- `N_TGT`, 4: number of routing targets.
- `N_SRC`, 2: sources summed per target (≥1).
- `clk`  in  1: single clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: global advance; low freezes FSM, pipeline and counters.
- `start`  in  1: frame request; accepted when `start && ready && enable`.
- `ready`  out  1: high only in IDLE.
- `weights`  in  `N_TGT*N_SRC*DW`: flat, entry k = t*N_SRC+s; latched at accept.
- `indices`  in  `N_TGT*N_SRC*VOICE_AW`: flat, same ordering; latched at accept.
- `val_addr`  out  VOICE_AW: voice RAM read address.
- `val_data`  in  DW: RAM read data, valid one enabled cycle after `val_addr`.
- `target`  out  `N_TGT*DW`: committed results, target t at bits [t*DW +: DW].
- `done`  out  1: one-cycle pulse when `target` is updated.

## Operation
- FSM states: IDLE → RUN on accept. RUN → DRAIN after step `S-1`, where `S = N_TGT*N_SRC`. DRAIN stays 2 cycles, then → DONE. DONE → IDLE after 1 cycle.
- At accept, `weights` and `indices` are snapshotted. Later input changes do not affect the frame.
- RUN step k drives `val_addr = idx[k]`.
- Pipeline stage P: `prod = w[k] * val_data`, a signed 2·DW product registered.
- Pipeline stage A: `acc = (s==0 ? 0 : acc) + prod`.
  - Accumulator width is `2*DW + clog2(N_SRC)`, so it never wraps.
- On the last source of target t, `work[t] = sat(acc >>> (DW-1))`.
  - `sat` clamps to [-2^(DW-1), 2^(DW-1)-1].
- Entering DONE, `work` is copied to `target` and `done` is high that cycle. `target` holds between frames.
- `start` while not ready is ignored (no queueing).
- `enable` low freezes every register except async reset. The RAM must use the same enable so that `val_data` stays aligned with `val_addr`.
- Reset, including mid-frame: state IDLE, `ready`=1, `done`=0, `val_addr`=0, `target`=0, all working registers 0. Any frame in flight is discarded.
- `val_addr` outside RUN: holds its last value (0 after reset).

## Timing
- Cycle 0 is the enabled accept cycle.
- RUN occupies cycles 1..S; step k drives `val_addr` in cycle k+1.
- `val_data` for step k arrives in cycle k+2. The product register loads at the end of k+2; the accumulate happens at the end of k+3.
- DRAIN occupies cycles S+1 and S+2. DONE is cycle S+3, with `done`=1 and the new `target` visible.
- `ready` returns in cycle S+4. The next accept can occur in S+4, giving throughput of one frame per S+4 enabled cycles.
- With the defaults (S=8), `done` is in cycle 11 and `ready` in cycle 12.
- Stalled cycles (`enable`=0) extend all of the above 1:1.

## Structure
- Package `fm_route_pkg`:
  - state enum `route_state_t` {IDLE, RUN, DRAIN, DONE};
  - function `sat_q` (arithmetic shift + clamp, parametrised by width);
  - localparam helpers for accumulator width.
- Sub-module `fm_mac_sat`:
  - product register and accumulator with a clear-on-first-source input;
  - saturated output and a result-valid strobe;
  - `enable` input.
- Top module: FSM, step counter (t, s), snapshot registers, `work` and `target` banks.

## Test plan
- **Basic sum:** defaults; RAM[i] = i·2^26; all weights 0x40000000 (0.5); `indices` for target t = {2t, 2t+1}.
  - Expect `target[t] = (4t+1)·2^25`.
  - `done` in cycle 11; `ready` low in cycles 1–11.
- **Positive saturation:** weights 0x80000000 (-1.0), values 0x80000000.
  - Both products are +1.0, sum 2.0, so `target` = 0x7FFFFFFF.
- **Negative saturation:** weights 0x7FFFFFFF, values 0x80000000.
  - Sum ≈ -2.0, so `target` = 0x80000000.
- **Stall and snapshot:** drop `enable` for 3 cycles mid-RUN and change `weights` and `indices` during RUN.
  - `done` moves to cycle 14.
  - Results equal the no-stall, pre-change results.
- **Reset mid-frame:** assert `reset_n` low in cycle 5.
  - All outputs 0 and `ready`=1 immediately.
  - A new frame after release gives correct results, with no residue from the aborted frame.
- **Parametrisation and busy start:** N_TGT=3, N_SRC=3, `start` held high continuously.
  - `done` every 13 cycles.
  - Start pulses during busy are ignored.
  - Results match the reference model.

Source files
------------

// File: rtl/fm_route_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed modulation-matrix router.
// Holds the FSM state type, accumulator sizing and the Q1.(DW-1) saturating rescale.
package fm_route_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } route_state_t;

    // Working width for the saturation helper; callers sign-extend into it.
    localparam int SAT_MAX_W = 128;

    function automatic int acc_width(input int dw, input int n_src);
        return 2 * dw + $clog2(n_src);
    endfunction

    // Drop the DW-1 fractional bits of a Q2.(2DW-2) sum and clamp it to signed DW bits.
    function automatic logic [SAT_MAX_W-1:0] sat_q(input logic signed [SAT_MAX_W-1:0] val,
                                                   input int dw);
        logic signed [SAT_MAX_W-1:0] one_s;
        logic signed [SAT_MAX_W-1:0] hi_s;
        logic signed [SAT_MAX_W-1:0] lo_s;
        logic signed [SAT_MAX_W-1:0] sh_s;
        logic [SAT_MAX_W-1:0]        res_s;
        one_s = SAT_MAX_W'(1'b1);
        hi_s  = (one_s <<< (dw - 1)) - one_s;
        lo_s  = ~hi_s;
        sh_s  = val >>> (dw - 1);
        if (sh_s > hi_s) begin
            res_s = hi_s;
        end else if (sh_s < lo_s) begin
            res_s = lo_s;
        end else begin
            res_s = sh_s;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/fm_mac_sat.sv
// Shared multiplier plus accumulator: one product per enabled cycle, accumulated over
// the sources of a target and presented saturated on the last source.
module fm_mac_sat
    import fm_route_pkg::*;
#(
    parameter int DW    = 32,
    parameter int N_SRC = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          in_valid,
    input  logic          in_first,
    input  logic          in_last,
    input  logic [DW-1:0] weight,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] res,
    output logic          res_valid
);

    localparam int PW    = 2 * DW;
    localparam int ACC_W = acc_width(DW, N_SRC);

    logic signed [DW-1:0]    w_s;
    logic signed [DW-1:0]    d_s;
    logic signed [PW-1:0]    prod_s;
    logic signed [PW-1:0]    prod_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] base_s;
    logic signed [ACC_W-1:0] sum_s;
    logic [SAT_MAX_W-1:0]    sat_s;
    logic                    valid_r;
    logic                    first_r;
    logic                    last_r;

    assign w_s = weight;
    assign d_s = data;

    // Full-precision signed product and the accumulate/saturate path.
    always_comb begin
        prod_s = PW'(w_s) * PW'(d_s);
        base_s = {ACC_W{1'b0}};
        if (first_r) begin
            base_s = {ACC_W{1'b0}};
        end else begin
            base_s = acc_r;
        end
        sum_s = base_s + ACC_W'(prod_r);
        sat_s = sat_q(SAT_MAX_W'(sum_s), DW);
    end

    assign res       = sat_s[DW-1:0];
    assign res_valid = valid_r & last_r;

    // Product stage and accumulator, both frozen while enable is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_r  <= {PW{1'b0}};
            acc_r   <= {ACC_W{1'b0}};
            valid_r <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (enable) begin
            prod_r  <= prod_s;
            valid_r <= in_valid;
            first_r <= in_first;
            last_r  <= in_last;
            if (valid_r) begin
                acc_r <= sum_s;
            end
        end
    end

endmodule

// File: rtl/fm_route_mac_seq.sv
// Modulation-matrix router: walks N_TGT*N_SRC weight x voice-value products through one
// shared MAC and commits the saturated per-target sums as a bank at the end of the frame.
module fm_route_mac_seq
    import fm_route_pkg::*;
#(
    parameter int DW       = 32,
    parameter int VOICE_AW = 4,
    parameter int N_TGT    = 4,
    parameter int N_SRC    = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic                             start,
    output logic                             ready,
    input  logic [N_TGT*N_SRC*DW-1:0]        weights,
    input  logic [N_TGT*N_SRC*VOICE_AW-1:0]  indices,
    output logic [VOICE_AW-1:0]              val_addr,
    input  logic [DW-1:0]                    val_data,
    output logic [N_TGT*DW-1:0]              target,
    output logic                             done
);

    localparam int S  = N_TGT * N_SRC;
    localparam int KW = $clog2(S + 1);
    localparam int TW = $clog2(N_TGT + 1);
    localparam int SW = $clog2(N_SRC + 1);

    route_state_t              state_r;
    route_state_t              state_nxt_s;
    logic [KW-1:0]             k_r;
    logic [KW-1:0]             k_nxt_s;
    logic [SW-1:0]             s_r;
    logic [TW-1:0]             t_r;
    logic                      drain_r;
    logic                      last_step_s;
    logic [S*DW-1:0]           w_snap_r;
    logic [S*VOICE_AW-1:0]     idx_snap_r;
    logic                      v1_r;
    logic                      first1_r;
    logic                      last1_r;
    logic [DW-1:0]             w1_r;
    logic [TW-1:0]             t1_r;
    logic [TW-1:0]             t2_r;
    logic [DW-1:0]             res_s;
    logic                      res_valid_s;
    logic [DW-1:0]             work_r   [N_TGT];
    logic [DW-1:0]             commit_s [N_TGT];
    logic [N_TGT*DW-1:0]       target_r;
    logic [VOICE_AW-1:0]       val_addr_r;
    logic                      ready_r;
    logic                      done_r;

    assign last_step_s = (k_r == KW'(S - 1));
    assign k_nxt_s     = k_r + KW'(1'b1);

    // Frame sequencing: accept, step through all products, drain the MAC pipe, commit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_step_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (drain_r) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, step counters, snapshot and the address/issue stage feeding the MAC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            k_r        <= {KW{1'b0}};
            s_r        <= {SW{1'b0}};
            t_r        <= {TW{1'b0}};
            drain_r    <= 1'b0;
            w_snap_r   <= {(S*DW){1'b0}};
            idx_snap_r <= {(S*VOICE_AW){1'b0}};
            val_addr_r <= {VOICE_AW{1'b0}};
            v1_r       <= 1'b0;
            first1_r   <= 1'b0;
            last1_r    <= 1'b0;
            w1_r       <= {DW{1'b0}};
            t1_r       <= {TW{1'b0}};
            t2_r       <= {TW{1'b0}};
        end else if (enable) begin
            state_r  <= state_nxt_s;
            ready_r  <= (state_nxt_s == IDLE);
            done_r   <= (state_nxt_s == DONE);
            v1_r     <= (state_r == RUN);
            first1_r <= (s_r == {SW{1'b0}});
            last1_r  <= (s_r == SW'(N_SRC - 1));
            w1_r     <= w_snap_r[k_r*DW +: DW];
            t1_r     <= t_r;
            t2_r     <= t1_r;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        w_snap_r   <= weights;
                        idx_snap_r <= indices;
                        val_addr_r <= indices[VOICE_AW-1:0];
                        k_r        <= {KW{1'b0}};
                        s_r        <= {SW{1'b0}};
                        t_r        <= {TW{1'b0}};
                        drain_r    <= 1'b0;
                    end
                end
                RUN: begin
                    if (!last_step_s) begin
                        k_r        <= k_nxt_s;
                        val_addr_r <= idx_snap_r[k_nxt_s*VOICE_AW +: VOICE_AW];
                    end
                    if (s_r == SW'(N_SRC - 1)) begin
                        s_r <= {SW{1'b0}};
                        t_r <= t_r + TW'(1'b1);
                    end else begin
                        s_r <= s_r + SW'(1'b1);
                    end
                end
                DRAIN:   drain_r <= ~drain_r;
                default: drain_r <= 1'b0;
            endcase
        end
    end

    fm_mac_sat #(
        .DW    (DW),
        .N_SRC (N_SRC)
    ) u_mac (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .in_valid  (v1_r),
        .in_first  (first1_r),
        .in_last   (last1_r),
        .weight    (w1_r),
        .data      (val_data),
        .res       (res_s),
        .res_valid (res_valid_s)
    );

    // The last target's result lands on the same edge as the commit, so bypass it in.
    always_comb begin
        for (int t = 0; t < N_TGT; t++) begin
            commit_s[t] = work_r[t];
            if (res_valid_s && (t2_r == TW'(t))) begin
                commit_s[t] = res_s;
            end else begin
                commit_s[t] = work_r[t];
            end
        end
    end

    // Working bank collects per-target results; committed bank updates entering DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < N_TGT; t++) begin
                work_r[t] <= {DW{1'b0}};
            end
            target_r <= {(N_TGT*DW){1'b0}};
        end else if (enable) begin
            for (int t = 0; t < N_TGT; t++) begin
                work_r[t] <= commit_s[t];
                if ((state_r == DRAIN) && (state_nxt_s == DONE)) begin
                    target_r[t*DW +: DW] <= commit_s[t];
                end
            end
        end
    end

    assign ready    = ready_r;
    assign done     = done_r;
    assign val_addr = val_addr_r;
    assign target   = target_r;

endmodule

// File: tb/tb_fm_route_mac_seq.sv
// Directed bench: default 4x2 router driven from a vector table, plus stall/snapshot,
// mid-frame reset and a 3x3 instance with start held high.
module tb_fm_route_mac_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         enable;
    logic         start_a;
    logic         start_b;

    logic [255:0] weights_a;
    logic [31:0]  indices_a;
    logic [3:0]   val_addr_a;
    logic [31:0]  val_data_a;
    logic [127:0] target_a;
    logic         ready_a;
    logic         done_a;

    logic [287:0] weights_b;
    logic [35:0]  indices_b;
    logic [3:0]   val_addr_b;
    logic [31:0]  val_data_b;
    logic [95:0]  target_b;
    logic         ready_b;
    logic         done_b;

    logic [31:0]  ram_a [16];
    logic [31:0]  ram_b [16];

    int checks   = 0;
    int failures = 0;

    fm_route_mac_seq #(.DW(32), .VOICE_AW(4), .N_TGT(4), .N_SRC(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .start(start_a), .ready(ready_a),
        .weights(weights_a), .indices(indices_a), .val_addr(val_addr_a),
        .val_data(val_data_a), .target(target_a), .done(done_a)
    );

    fm_route_mac_seq #(.DW(32), .VOICE_AW(4), .N_TGT(3), .N_SRC(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .start(start_b), .ready(ready_b),
        .weights(weights_b), .indices(indices_b), .val_addr(val_addr_b),
        .val_data(val_data_b), .target(target_b), .done(done_b)
    );

    always @(posedge clk) begin
        if (enable) begin
            val_data_a <= ram_a[val_addr_a];
            val_data_b <= ram_b[val_addr_b];
        end
    end

    typedef struct packed {
        logic         ramp;
        logic [31:0]  w;
        logic [31:0]  val;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_a(input vec_t v);
        for (int i = 0; i < 16; i++) begin
            ram_a[i] = v.ramp ? (32'(i) << 26) : v.val;
        end
        for (int k = 0; k < 8; k++) begin
            weights_a[k*32 +: 32] = v.w;
            indices_a[k*4 +: 4]   = 4'(k);
        end
    endtask

    // Issues one frame on dut_a; returns at the negedge of the cycle after done.
    task automatic frame_a(input int stall_at, input bit perturb,
                           output int done_cyc, output bit ready_ok, output bit addr_ok);
        int cyc;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a  = 1'b0;
        cyc      = 1;
        done_cyc = -1;
        ready_ok = 1'b1;
        addr_ok  = 1'b1;
        while (cyc < 40 && done_cyc < 0) begin
            if (ready_a) ready_ok = 1'b0;
            if (done_a) done_cyc = cyc;
            if (stall_at == 0 && cyc <= 8 && val_addr_a !== 4'(cyc - 1)) addr_ok = 1'b0;
            if (stall_at != 0 && cyc == stall_at) enable = 1'b0;
            if (stall_at != 0 && cyc == stall_at + 3) enable = 1'b1;
            if (perturb && cyc == 3) begin
                weights_a = '0;
                indices_a = '1;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_targets_a(input string tag, input logic [127:0] exp);
        for (int t = 0; t < 4; t++) begin
            chk($sformatf("%s_target%0d", tag, t), target_a[t*32 +: 32], exp[t*32 +: 32]);
        end
    endtask

    initial begin
        int  dc;
        bit  rok;
        bit  aok;
        int  dcb [3];
        int  nd;
        logic [95:0] exp_b;

        vecs[0] = '{ramp: 1'b1, w: 32'h4000_0000, val: 32'h0,
                    exp: {32'h1A00_0000, 32'h1200_0000, 32'h0A00_0000, 32'h0200_0000}};
        vecs[1] = '{ramp: 1'b0, w: 32'h8000_0000, val: 32'h8000_0000, exp: {4{32'h7FFF_FFFF}}};
        vecs[2] = '{ramp: 1'b0, w: 32'h7FFF_FFFF, val: 32'h8000_0000, exp: {4{32'h8000_0000}}};
        vecs[3] = '{ramp: 1'b0, w: 32'h4000_0000, val: 32'h4000_0000, exp: {4{32'h4000_0000}}};
        vecs[4] = '{ramp: 1'b1, w: 32'hC000_0000, val: 32'h0,
                    exp: {32'hE600_0000, 32'hEE00_0000, 32'hF600_0000, 32'hFE00_0000}};

        reset_n   = 1'b0;
        enable    = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        weights_a = '0;
        indices_a = '0;
        weights_b = '0;
        indices_b = '0;
        for (int i = 0; i < 16; i++) begin
            ram_a[i] = 32'h0;
            ram_b[i] = 32'(i) << 26;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready_a), 32'd1);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_addr", 32'(val_addr_a), 32'd0);
        chk("rst_target", target_a[31:0] | target_a[63:32] | target_a[95:64] | target_a[127:96],
            32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            load_a(vecs[v]);
            frame_a(0, 1'b0, dc, rok, aok);
            chk($sformatf("v%0d_done_cycle", v), 32'(dc), 32'd11);
            chk($sformatf("v%0d_ready_low", v), 32'(rok), 32'd1);
            chk($sformatf("v%0d_addr_seq", v), 32'(aok), 32'd1);
            chk($sformatf("v%0d_ready_back", v), 32'(ready_a), 32'd1);
            chk($sformatf("v%0d_done_pulse", v), 32'(done_a), 32'd0);
            check_targets_a($sformatf("v%0d", v), vecs[v].exp);
        end

        // Stall three cycles mid-RUN and change inputs after accept.
        load_a(vecs[0]);
        frame_a(3, 1'b1, dc, rok, aok);
        chk("stall_done_cycle", 32'(dc), 32'd14);
        chk("stall_ready_low", 32'(rok), 32'd1);
        check_targets_a("stall", vecs[0].exp);

        // Reset in cycle 5 of a saturating frame, then a clean frame.
        load_a(vecs[1]);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready_a), 32'd1);
        chk("midrst_done", 32'(done_a), 32'd0);
        chk("midrst_addr", 32'(val_addr_a), 32'd0);
        chk("midrst_target", target_a[31:0] | target_a[63:32] | target_a[95:64] | target_a[127:96],
            32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        load_a(vecs[0]);
        frame_a(0, 1'b0, dc, rok, aok);
        chk("postrst_done_cycle", 32'(dc), 32'd11);
        check_targets_a("postrst", vecs[0].exp);

        // 3x3 instance, start held high: frames back to back every S+4 = 13 cycles.
        for (int k = 0; k < 9; k++) begin
            indices_b[k*4 +: 4] = 4'(k);
            case (k / 3)
                0:       weights_b[k*32 +: 32] = 32'h4000_0000;
                1:       weights_b[k*32 +: 32] = 32'h8000_0000;
                default: weights_b[k*32 +: 32] = 32'h2000_0000;
            endcase
        end
        exp_b = {32'h1500_0000, 32'hD000_0000, 32'h0600_0000};
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        nd = 0;
        for (int cyc = 1; cyc < 60 && nd < 3; cyc++) begin
            if (done_b) begin
                dcb[nd] = cyc;
                for (int t = 0; t < 3; t++) begin
                    chk($sformatf("b_f%0d_target%0d", nd, t), target_b[t*32 +: 32],
                        exp_b[t*32 +: 32]);
                end
                nd++;
            end
            @(negedge clk);
        end
        start_b = 1'b0;
        chk("b_frames_seen", 32'(nd), 32'd3);
        if (nd == 3) begin
            chk("b_first_done", 32'(dcb[0]), 32'd12);
            chk("b_period1", 32'(dcb[1] - dcb[0]), 32'd13);
            chk("b_period2", 32'(dcb[2] - dcb[1]), 32'd13);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
